// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with on-chip baud tick generator, 3-sample majority
// voting, 5..8 data bits, optional parity, 1/2 stop bits, break detection and an RX FIFO.
// Ports:
//   clk, rst (async, active-low)
//   rx                    serial input (async to clk, idle high)
//   baud_div              oversample tick every baud_div+1 clocks
//   data_size/parity_en/parity_mode/stop_bit_size   frame format, latched per frame
//   m_data/m_err_parity/m_err_frame/m_valid/m_ready FIFO head, valid/ready handshake
//   overrun/clr_overrun   sticky dropped-word flag and its clear
//   break_det             one-clock pulse when a break frame is pushed
//   busy                  receiver is inside a frame
module uart_rx_os #(
    parameter int unsigned OSR        = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_size,
    input  logic             parity_en,
    input  logic [1:0]       parity_mode,
    input  logic             stop_bit_size,
    output logic [7:0]       m_data,
    output logic             m_err_parity,
    output logic             m_err_frame,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic             break_det,
    output logic             busy
);

    localparam int unsigned OS_W   = $clog2(OSR);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = AW + 1;
    localparam int unsigned WORD_W = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Synchronizer and edge history
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    // Timing
    logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    // Frame state
    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       vote_q, vote_d;
    logic [1:0]       size_q, size_d;
    logic             pen_q, pen_d;
    logic [1:0]       pmode_q, pmode_d;
    logic             stop2_q, stop2_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             par_bit_q, par_bit_d;
    logic             stop_idx_q, stop_idx_d;
    logic             stop0_zero_q, stop0_zero_d;
    // FIFO
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    // Registered outputs
    logic [7:0]       m_data_q, m_data_d;
    logic             m_err_parity_q, m_err_parity_d;
    logic             m_err_frame_q, m_err_frame_d;
    logic             m_valid_q, m_valid_d;
    logic             overrun_q, overrun_d;
    logic             break_det_q, break_det_d;
    logic             busy_q, busy_d;

    logic              tick_c, start_det_c, maj_c;
    logic              at_s0_c, at_s1_c, at_res_c, at_end_c;
    logic              push_c, brk_c;
    logic [WORD_W-1:0] push_word_c;
    logic              pop_c, full_c, wr_en_c, ovr_set_c;
    logic [WORD_W-1:0] head_c;

    assign tick_c      = (tick_cnt_q == baud_div);
    assign start_det_c = (state_q == S_IDLE) && rx_prev_q && !rx_sync_q;
    assign at_s0_c     = tick_c && (os_cnt_q == OS_W'(OSR / 2 - 1));
    assign at_s1_c     = tick_c && (os_cnt_q == OS_W'(OSR / 2));
    assign at_res_c    = tick_c && (os_cnt_q == OS_W'(OSR / 2 + 1));
    assign at_end_c    = tick_c && (os_cnt_q == OS_W'(OSR - 1));
    assign maj_c       = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_sync_q) | (vote_q[1] & rx_sync_q);

    // Receive FSM, tick/sample counters and per-frame bookkeeping
    always_comb begin
        tick_cnt_d   = tick_c ? '0 : tick_cnt_q + DIV_W'(1);
        os_cnt_d     = os_cnt_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        vote_d       = vote_q;
        size_d       = size_q;
        pen_d        = pen_q;
        pmode_d      = pmode_q;
        stop2_d      = stop2_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        par_bit_d    = par_bit_q;
        stop_idx_d   = stop_idx_q;
        stop0_zero_d = stop0_zero_q;
        push_c       = 1'b0;
        push_word_c  = '0;
        brk_c        = 1'b0;

        if (tick_c) begin
            os_cnt_d = at_end_c ? '0 : os_cnt_q + OS_W'(1);
        end
        if (at_s0_c) begin
            vote_d[0] = rx_sync_q;
        end
        if (at_s1_c) begin
            vote_d[1] = rx_sync_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_det_c) begin
                    state_d      = S_START;
                    tick_cnt_d   = '0;
                    os_cnt_d     = '0;
                    size_d       = data_size;
                    pen_d        = parity_en;
                    pmode_d      = parity_mode;
                    stop2_d      = stop_bit_size;
                    bit_cnt_d    = '0;
                    data_d       = '0;
                    perr_d       = 1'b0;
                    ferr_d       = 1'b0;
                    par_bit_d    = 1'b0;
                    stop_idx_d   = 1'b0;
                    stop0_zero_d = 1'b0;
                end
            end
            S_START: begin
                if (at_res_c && maj_c) begin
                    state_d = S_IDLE;
                end else if (at_end_c) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (at_res_c) begin
                    data_d[bit_cnt_q] = maj_c;
                end
                if (at_end_c) begin
                    if (bit_cnt_q == 3'd4 + 3'(size_q)) begin
                        bit_cnt_d = '0;
                        state_d   = pen_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (at_res_c) begin
                    par_bit_d = maj_c;
                    perr_d    = maj_c != (pmode_q[0] ^ (pmode_q[1] & (^data_q)));
                end
                if (at_end_c) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (at_res_c) begin
                    ferr_d = ferr_q | !maj_c;
                    if (!stop_idx_q) begin
                        stop0_zero_d = !maj_c;
                    end
                    // Leave half a bit early so an immediately following start bit is seen
                    if (stop_idx_q == stop2_q) begin
                        push_c      = 1'b1;
                        push_word_c = {ferr_q | !maj_c, perr_q, data_q};
                        brk_c       = (data_q == 8'd0) && (!pen_q || !par_bit_q) &&
                                      (stop_idx_q ? stop0_zero_q : !maj_c);
                        state_d     = S_IDLE;
                    end
                end else if (at_end_c) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers, storage, overrun and registered head view
    always_comb begin
        pop_c     = (count_q != '0) && m_ready;
        full_c    = (count_q == CNT_W'(FIFO_DEPTH));
        wr_en_c   = push_c && (!full_c || pop_c);
        ovr_set_c = push_c && full_c && !pop_c;

        mem_d = mem_q;
        if (wr_en_c) begin
            mem_d[wr_ptr_q] = push_word_c;
        end
        wr_ptr_d = wr_ptr_q + AW'(wr_en_c);
        rd_ptr_d = rd_ptr_q + AW'(pop_c);
        count_d  = count_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);

        head_c         = (count_d != '0) ? mem_d[rd_ptr_d] : '0;
        m_data_d       = head_c[7:0];
        m_err_parity_d = head_c[8];
        m_err_frame_d  = head_c[9];
        m_valid_d      = (count_d != '0);

        // A fresh overrun beats a simultaneous clear
        overrun_d = overrun_q;
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (ovr_set_c) begin
            overrun_d = 1'b1;
        end

        break_det_d = brk_c;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q      <= 1'b1;
            rx_sync_q      <= 1'b1;
            rx_prev_q      <= 1'b1;
            tick_cnt_q     <= '0;
            os_cnt_q       <= '0;
            state_q        <= S_IDLE;
            bit_cnt_q      <= '0;
            data_q         <= '0;
            vote_q         <= 2'b11;
            size_q         <= '0;
            pen_q          <= 1'b0;
            pmode_q        <= '0;
            stop2_q        <= 1'b0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            par_bit_q      <= 1'b0;
            stop_idx_q     <= 1'b0;
            stop0_zero_q   <= 1'b0;
            mem_q          <= '{default: '0};
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            m_data_q       <= '0;
            m_err_parity_q <= 1'b0;
            m_err_frame_q  <= 1'b0;
            m_valid_q      <= 1'b0;
            overrun_q      <= 1'b0;
            break_det_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            rx_meta_q      <= rx;
            rx_sync_q      <= rx_meta_q;
            rx_prev_q      <= rx_sync_q;
            tick_cnt_q     <= tick_cnt_d;
            os_cnt_q       <= os_cnt_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            data_q         <= data_d;
            vote_q         <= vote_d;
            size_q         <= size_d;
            pen_q          <= pen_d;
            pmode_q        <= pmode_d;
            stop2_q        <= stop2_d;
            perr_q         <= perr_d;
            ferr_q         <= ferr_d;
            par_bit_q      <= par_bit_d;
            stop_idx_q     <= stop_idx_d;
            stop0_zero_q   <= stop0_zero_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            m_data_q       <= m_data_d;
            m_err_parity_q <= m_err_parity_d;
            m_err_frame_q  <= m_err_frame_d;
            m_valid_q      <= m_valid_d;
            overrun_q      <= overrun_d;
            break_det_q    <= break_det_d;
            busy_q         <= busy_d;
        end
    end

    assign m_data       = m_data_q;
    assign m_err_parity = m_err_parity_q;
    assign m_err_frame  = m_err_frame_q;
    assign m_valid      = m_valid_q;
    assign overrun      = overrun_q;
    assign break_det    = break_det_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frame table plus hand-written corner sequences.
module tb_uart_rx_os;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] baud_div;
    logic [1:0]  data_size;
    logic        parity_en;
    logic [1:0]  parity_mode;
    logic        stop_bit_size;
    logic [7:0]  m_data;
    logic        m_err_parity, m_err_frame, m_valid, m_ready;
    logic        overrun, clr_overrun, break_det, busy;

    int checks = 0;
    int errors = 0;
    int brk_cnt = 0;

    uart_rx_os #(.OSR(16), .DIV_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div),
        .data_size(data_size), .parity_en(parity_en), .parity_mode(parity_mode),
        .stop_bit_size(stop_bit_size), .m_data(m_data), .m_err_parity(m_err_parity),
        .m_err_frame(m_err_frame), .m_valid(m_valid), .m_ready(m_ready),
        .overrun(overrun), .clr_overrun(clr_overrun), .break_det(break_det), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (break_det === 1'b1) brk_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] size;
        logic       pen;
        logic [1:0] pmode;
        logic       stop2;
        logic [7:0] data;
        logic       pbit;
        logic [1:0] stops;     // [0] first stop bit, [1] second stop bit
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        int         exp_brk;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [1:0] size, input logic pen, input logic [1:0] pmode,
                                input logic stop2, input logic [7:0] data, input logic pbit,
                                input logic [1:0] stops, input logic [7:0] exp_data,
                                input logic exp_perr, input logic exp_ferr, input int exp_brk);
        vec_t v;
        v.size = size; v.pen = pen; v.pmode = pmode; v.stop2 = stop2; v.data = data;
        v.pbit = pbit; v.stops = stops; v.exp_data = exp_data; v.exp_perr = exp_perr;
        v.exp_ferr = exp_ferr; v.exp_brk = exp_brk;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] size, input logic pen, input logic [1:0] pmode,
                           input logic stop2);
        data_size = size; parity_en = pen; parity_mode = pmode; stop_bit_size = stop2;
    endtask

    // Drives one frame on rx (16 clocks per bit at baud_div=0), then idles high for tail clocks
    task automatic send_frame(input logic [1:0] size, input logic pen, input logic [7:0] data,
                              input logic pbit, input logic stop2, input logic [1:0] stops,
                              input int tail);
        int n;
        n = 5 + int'(size);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            rx = data[i];
            repeat (16) @(negedge clk);
        end
        if (pen) begin
            rx = pbit;
            repeat (16) @(negedge clk);
        end
        rx = stops[0];
        repeat (16) @(negedge clk);
        if (stop2) begin
            rx = stops[1];
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
        repeat (tail) @(negedge clk);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (m_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(m_valid), 32'd1);
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rx = 1'b1; baud_div = '0; m_ready = 1'b0; clr_overrun = 1'b0;
        set_cfg(2'b11, 1'b0, 2'b00, 1'b0);

        vecs[0]  = mk(2'b11, 0, 2'b00, 0, 8'h5A, 0, 2'b11, 8'h5A, 0, 0, 0); // 8N1
        vecs[1]  = mk(2'b10, 1, 2'b10, 0, 8'h35, 1, 2'b11, 8'h35, 1, 0, 0); // 7E1 wrong parity
        vecs[2]  = mk(2'b10, 1, 2'b10, 0, 8'h35, 0, 2'b11, 8'h35, 0, 0, 0); // 7E1 good parity
        vecs[3]  = mk(2'b11, 0, 2'b00, 1, 8'h3C, 0, 2'b01, 8'h3C, 0, 1, 0); // 8N2 2nd stop 0
        vecs[4]  = mk(2'b11, 0, 2'b00, 0, 8'h00, 0, 2'b00, 8'h00, 0, 1, 1); // 8N1 break
        vecs[5]  = mk(2'b00, 0, 2'b00, 0, 8'hFF, 0, 2'b11, 8'h1F, 0, 0, 0); // 5N1
        vecs[6]  = mk(2'b01, 1, 2'b11, 0, 8'h2A, 0, 2'b11, 8'h2A, 0, 0, 0); // 6O1
        vecs[7]  = mk(2'b11, 1, 2'b01, 0, 8'h81, 0, 2'b11, 8'h81, 1, 0, 0); // mark, bit 0
        vecs[8]  = mk(2'b11, 1, 2'b00, 0, 8'hFF, 0, 2'b11, 8'hFF, 0, 0, 0); // space, bit 0
        vecs[9]  = mk(2'b11, 1, 2'b10, 0, 8'h00, 0, 2'b00, 8'h00, 0, 1, 1); // 8E1 break
        vecs[10] = mk(2'b11, 1, 2'b10, 0, 8'h00, 1, 2'b00, 8'h00, 1, 1, 0); // parity 1: no break
        vecs[11] = mk(2'b11, 0, 2'b00, 1, 8'h00, 0, 2'b10, 8'h00, 0, 1, 1); // 8N2 1st stop 0

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_break", 32'(break_det), 0);
        check("rst_errs", 32'({m_err_parity, m_err_frame}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 0xA5 with m_ready=1: head appears exactly one clock after last-stop resolve
        set_cfg(2'b11, 1'b0, 2'b00, 1'b0);
        m_ready = 1'b1;
        fork
            send_frame(2'b11, 1'b0, 8'hA5, 1'b0, 1'b0, 2'b11, 10);
            begin
                repeat (156) @(posedge clk);
                #1 check("lat_before", 32'(m_valid), 0);
                @(posedge clk);
                #1 check("lat_valid", 32'(m_valid), 1);
                check("lat_data", 32'(m_data), 32'hA5);
                check("lat_errs", 32'({m_err_parity, m_err_frame}), 0);
                @(posedge clk);
                #1 check("lat_popped", 32'(m_valid), 0);
            end
        join
        m_ready = 1'b0;
        check("lat_busy", 32'(busy), 0);

        // Table of frames, one word each, popped after checking
        for (int i = 0; i < 12; i++) begin
            int brk0;
            brk0 = brk_cnt;
            set_cfg(vecs[i].size, vecs[i].pen, vecs[i].pmode, vecs[i].stop2);
            send_frame(vecs[i].size, vecs[i].pen, vecs[i].data, vecs[i].pbit, vecs[i].stop2,
                       vecs[i].stops, 20);
            wait_valid($sformatf("v%0d_valid", i));
            check($sformatf("v%0d_data", i), 32'(m_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_perr", i), 32'(m_err_parity), 32'(vecs[i].exp_perr));
            check($sformatf("v%0d_ferr", i), 32'(m_err_frame), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_brk", i), 32'(brk_cnt - brk0), 32'(vecs[i].exp_brk));
            check($sformatf("v%0d_busy", i), 32'(busy), 0);
            pop_one();
            check($sformatf("v%0d_empty", i), 32'(m_valid), 0);
        end

        // False start: rx low 4 clocks
        set_cfg(2'b11, 1'b0, 2'b00, 1'b0);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("fs_busy_hi", 32'(busy), 1);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("fs_busy_lo", 32'(busy), 0);
        check("fs_no_push", 32'(m_valid), 0);

        // Overrun: DEPTH+1 words with no consumer
        for (int i = 1; i <= 5; i++) begin
            send_frame(2'b11, 1'b0, 8'(i), 1'b0, 1'b0, 2'b11, 4);
            if (i == 4) check("ovr_not_yet", 32'(overrun), 0);
        end
        check("ovr_set", 32'(overrun), 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_order%0d", i), 32'(m_data), 32'(i));
            pop_one();
        end
        check("ovr_drained", 32'(m_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("ovr_clr", 32'(overrun), 0);

        // Reset mid-DATA flushes a queued word and aborts the frame
        send_frame(2'b11, 1'b0, 8'h77, 1'b0, 1'b0, 2'b11, 4);
        check("mr_queued", 32'(m_valid), 1);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("mr_busy_pre", 32'(busy), 1);
        rst = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("mr_valid", 32'(m_valid), 0);
        check("mr_data", 32'(m_data), 0);
        check("mr_busy", 32'(busy), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("mr_idle", 32'(m_valid), 0);

        // 8O1 0x3C after reset: four ones, so odd parity bit is 1
        set_cfg(2'b11, 1'b1, 2'b11, 1'b0);
        send_frame(2'b11, 1'b1, 8'h3C, 1'b1, 1'b0, 2'b11, 20);
        wait_valid("post_valid");
        check("post_data", 32'(m_data), 32'h3C);
        check("post_errs", 32'({m_err_parity, m_err_frame}), 0);
        pop_one();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
